// File: rtl/scr1_tapc_pkg.sv
// Shared types and helpers for the TAP controller data-register bank.
package scr1_tapc_pkg;

    localparam int SCR1_TAPC_DR_LEN_W = 8;
    localparam int SCR1_TAPC_MASK_W   = 256;

    typedef logic [SCR1_TAPC_DR_LEN_W-1:0] type_scr1_tapc_dr_len_v;

    // Select width; one extra code is reserved so out-of-range selects reach BYPASS
    function automatic int scr1_tapc_sel_w(input int num_dr);
        return $clog2(num_dr + 1);
    endfunction

    function automatic logic [SCR1_TAPC_MASK_W-1:0] scr1_tapc_len_mask(input type_scr1_tapc_dr_len_v len);
        logic [SCR1_TAPC_MASK_W-1:0] m;
        m = '0;
        for (int i = 0; i < SCR1_TAPC_MASK_W; i++) m[i] = (i < int'(len));
        return m;
    endfunction

endpackage

// File: rtl/scr1_tapc_dr_upd_hs.sv
// Per-DR update handshake: pending-data valid flag and sticky overrun flag.
module scr1_tapc_dr_upd_hs (
    input  logic clk,
    input  logic rst,
    input  logic upd_acc,
    input  logic upd_rdy,
    input  logic ovr_clr,
    output logic upd_vld,
    output logic upd_ovr
);

    always_ff @(posedge clk) begin
        if (rst) begin
            upd_vld <= 1'b0;
            upd_ovr <= 1'b0;
        end else begin
            // a fresh update keeps vld high even if the old data is consumed this cycle
            if (upd_acc)      upd_vld <= 1'b1;
            else if (upd_rdy) upd_vld <= 1'b0;

            if (upd_acc && upd_vld && !upd_rdy) upd_ovr <= 1'b1;
            else if (ovr_clr)                   upd_ovr <= 1'b0;
        end
    end

endmodule

// File: rtl/scr1_tapc_dr_bank.sv
// Bank of JTAG data registers of individual lengths sharing one shift register,
// with BYPASS for unmapped selects, shift-length check and per-DR update handshake.
module scr1_tapc_dr_bank
    import scr1_tapc_pkg::*;
#(
    parameter int SCR1_NUM_DR    = 4,
    parameter int SCR1_MAX_WIDTH = 32,
    parameter logic [SCR1_NUM_DR*SCR1_TAPC_DR_LEN_W-1:0] SCR1_DR_LEN = {8'd32, 8'd16, 8'd8, 8'd1},
    parameter logic [SCR1_NUM_DR*SCR1_MAX_WIDTH-1:0]     SCR1_RESET_VALUE = '0,
    parameter bit   SCR1_LEN_CHECK = 1'b1,
    localparam int  SEL_W = scr1_tapc_sel_w(SCR1_NUM_DR)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  fsm_dr_capture,
    input  logic                                  fsm_dr_shift,
    input  logic                                  fsm_dr_update,
    input  logic [SEL_W-1:0]                      dr_sel,
    input  logic                                  din_serial,
    input  logic [SCR1_NUM_DR*SCR1_MAX_WIDTH-1:0] din_parallel,
    output logic                                  dout_serial,
    output logic [SCR1_NUM_DR*SCR1_MAX_WIDTH-1:0] dout_parallel,
    output logic [SCR1_NUM_DR-1:0]                upd_vld,
    input  logic [SCR1_NUM_DR-1:0]                upd_rdy,
    input  logic [SCR1_NUM_DR-1:0]                ovr_clr,
    output logic [SCR1_NUM_DR-1:0]                upd_ovr,
    output logic                                  len_err
);

    localparam int NDR   = SCR1_NUM_DR;
    localparam int MW    = SCR1_MAX_WIDTH;
    localparam int IDX_W = (NDR > 1) ? $clog2(NDR) : 1;
    localparam int CNT_W = $clog2(MW + 2);
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(MW + 1);

    type_scr1_tapc_dr_len_v len_lut  [NDR];
    logic [MW-1:0]          mask_lut [NDR];
    logic [MW-1:0]          din_arr  [NDR];

    logic [MW-1:0]          sr;
    logic                   bypass;
    logic [CNT_W-1:0]       cnt;

    logic                   sel_vld;
    logic [IDX_W-1:0]       sel_idx;
    type_scr1_tapc_dr_len_v cur_len;
    logic [MW-1:0]          cur_mask;
    logic [MW-1:0]          top_bit;
    logic [MW-1:0]          sr_shift;
    logic                   cnt_hit;
    logic                   upd_go;
    logic                   upd_ok;
    logic                   upd_rej;
    logic [NDR-1:0]         upd_acc;

    assign sel_vld  = (dr_sel < SEL_W'(NDR));
    assign sel_idx  = sel_vld ? dr_sel[IDX_W-1:0] : '0;
    assign cur_len  = len_lut[sel_idx];
    assign cur_mask = mask_lut[sel_idx];

    // new bit enters at L-1; bits at and above L stay zero
    assign top_bit  = cur_mask & ~(cur_mask >> 1);
    assign sr_shift = ((sr >> 1) & (cur_mask >> 1)) | (top_bit & {MW{din_serial}});

    assign cnt_hit  = (32'(cnt) == 32'(cur_len));
    assign upd_go   = fsm_dr_update && !fsm_dr_capture && !fsm_dr_shift && sel_vld;
    assign upd_ok   = upd_go && (!SCR1_LEN_CHECK || cnt_hit);
    assign upd_rej  = upd_go && SCR1_LEN_CHECK && !cnt_hit;

    assign dout_serial = sel_vld ? sr[0] : bypass;

    always_ff @(posedge clk) begin
        if (rst) begin
            sr      <= '0;
            bypass  <= 1'b0;
            cnt     <= '0;
            len_err <= 1'b0;
        end else begin
            len_err <= 1'b0;
            if (fsm_dr_capture) begin
                if (sel_vld) begin
                    sr  <= din_arr[sel_idx] & cur_mask;
                    cnt <= '0;
                end else begin
                    bypass <= 1'b0;
                end
            end else if (fsm_dr_shift) begin
                if (sel_vld) begin
                    sr <= sr_shift;
                    if (cnt != CNT_SAT) cnt <= cnt + CNT_W'(1);
                end else begin
                    bypass <= din_serial;
                end
            end else if (fsm_dr_update) begin
                len_err <= upd_rej;
            end
        end
    end

    for (genvar i = 0; i < NDR; i++) begin : g_dr
        // length list is written DR0-first, so DR0 sits in the top byte
        localparam type_scr1_tapc_dr_len_v LEN =
            SCR1_DR_LEN[(NDR-1-i)*SCR1_TAPC_DR_LEN_W +: SCR1_TAPC_DR_LEN_W];
        localparam logic [MW-1:0] MASK = MW'(scr1_tapc_len_mask(LEN));

        logic [MW-1:0] shadow;

        assign len_lut[i]  = LEN;
        assign mask_lut[i] = MASK;
        assign din_arr[i]  = din_parallel[i*MW +: MW];
        assign upd_acc[i]  = upd_ok && (sel_idx == IDX_W'(i));

        always_ff @(posedge clk) begin
            if (rst)             shadow <= SCR1_RESET_VALUE[i*MW +: MW] & MASK;
            else if (upd_acc[i]) shadow <= sr & MASK;
        end

        assign dout_parallel[i*MW +: MW] = shadow;

        scr1_tapc_dr_upd_hs u_hs (
            .clk     (clk),
            .rst     (rst),
            .upd_acc (upd_acc[i]),
            .upd_rdy (upd_rdy[i]),
            .ovr_clr (ovr_clr[i]),
            .upd_vld (upd_vld[i]),
            .upd_ovr (upd_ovr[i])
        );
    end

endmodule

// File: tb/tb_scr1_tapc_dr_bank.sv
// Scoreboard bench for scr1_tapc_dr_bank: TDO bits are queued at capture and popped while shifting.
module tb_scr1_tapc_dr_bank;

    localparam int NDR   = 4;
    localparam int MW    = 32;
    localparam int SEL_W = 3;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                fsm_dr_capture = 1'b0;
    logic                fsm_dr_shift = 1'b0;
    logic                fsm_dr_update = 1'b0;
    logic [SEL_W-1:0]    dr_sel = '0;
    logic                din_serial = 1'b0;
    logic [NDR*MW-1:0]   din_parallel = '0;
    logic                dout_serial;
    logic [NDR*MW-1:0]   dout_parallel;
    logic [NDR-1:0]      upd_vld;
    logic [NDR-1:0]      upd_rdy = '0;
    logic [NDR-1:0]      ovr_clr = '0;
    logic [NDR-1:0]      upd_ovr;
    logic                len_err;

    int total = 0;
    int bad   = 0;
    logic [31:0] sb_q[$];

    scr1_tapc_dr_bank #(
        .SCR1_NUM_DR      (NDR),
        .SCR1_MAX_WIDTH   (MW),
        .SCR1_DR_LEN      ({8'd32, 8'd16, 8'd8, 8'd1}),
        .SCR1_RESET_VALUE ({(NDR*MW){1'b1}}),
        .SCR1_LEN_CHECK   (1'b1)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .fsm_dr_capture (fsm_dr_capture),
        .fsm_dr_shift   (fsm_dr_shift),
        .fsm_dr_update  (fsm_dr_update),
        .dr_sel         (dr_sel),
        .din_serial     (din_serial),
        .din_parallel   (din_parallel),
        .dout_serial    (dout_serial),
        .dout_parallel  (dout_parallel),
        .upd_vld        (upd_vld),
        .upd_rdy        (upd_rdy),
        .ovr_clr        (ovr_clr),
        .upd_ovr        (upd_ovr),
        .len_err        (len_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic sb_pop(input string tag, input logic [31:0] got);
        if (sb_q.size() == 0) chk({tag, "_underflow"}, 32'(sb_q.size()), 32'd1);
        else                  chk(tag, got, sb_q.pop_front());
    endtask

    task automatic push_bits(input logic [31:0] v, input int n);
        for (int k = 0; k < n; k++) sb_q.push_back({31'b0, v[k]});
    endtask

    function automatic logic [31:0] sh(input int i);
        return dout_parallel[i*MW +: MW];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cap(input int sel);
        dr_sel = SEL_W'(sel);
        fsm_dr_capture = 1'b1;
        step();
        fsm_dr_capture = 1'b0;
    endtask

    task automatic shf(input logic [31:0] d, input int n, input bit chk_tdo);
        fsm_dr_shift = 1'b1;
        for (int k = 0; k < n; k++) begin
            din_serial = d[k];
            if (chk_tdo) sb_pop("tdo", {31'b0, dout_serial});
            step();
        end
        fsm_dr_shift = 1'b0;
    endtask

    task automatic upd();
        fsm_dr_update = 1'b1;
        step();
        fsm_dr_update = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_sh0"}, sh(0), 32'hFFFF_FFFF);
        chk({tag, "_sh1"}, sh(1), 32'h0000_FFFF);
        chk({tag, "_sh2"}, sh(2), 32'h0000_00FF);
        chk({tag, "_sh3"}, sh(3), 32'h0000_0001);
        chk({tag, "_vld"}, 32'(upd_vld), 32'h0);
        chk({tag, "_ovr"}, 32'(upd_ovr), 32'h0);
        chk({tag, "_tdo"}, 32'(dout_serial), 32'h0);
        chk({tag, "_lerr"}, 32'(len_err), 32'h0);
    endtask

    initial begin
        // reset
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk_reset("rst");

        // DR1, 16 bits; upper capture bits must be dropped
        din_parallel[1*MW +: MW] = 32'hDEAD_A5C3;
        cap(1);
        push_bits(32'h0000_A5C3, 16);
        shf(32'h0000_1234, 16, 1'b1);
        upd();
        chk("dr1_sh", sh(1), 32'h0000_1234);
        chk("dr1_vld", 32'(upd_vld), 32'h2);
        chk("dr1_ovr", 32'(upd_ovr), 32'h0);
        chk("dr1_lerr", 32'(len_err), 32'h0);
        chk("dr1_sh0", sh(0), 32'hFFFF_FFFF);
        upd_rdy = 4'b0010;
        step();
        upd_rdy = '0;
        chk("dr1_vld_clr", 32'(upd_vld), 32'h0);

        // length check on DR2: short and long shifts both rejected
        din_parallel[2*MW +: MW] = 32'h0000_005A;
        cap(2);
        shf(32'h0000_007F, 7, 1'b0);
        upd();
        chk("len7_err", 32'(len_err), 32'h1);
        chk("len7_sh", sh(2), 32'h0000_00FF);
        chk("len7_vld", 32'(upd_vld), 32'h0);
        step();
        chk("len7_pulse", 32'(len_err), 32'h0);
        cap(2);
        shf(32'h0000_0155, 9, 1'b0);
        upd();
        chk("len9_err", 32'(len_err), 32'h1);
        chk("len9_sh", sh(2), 32'h0000_00FF);
        chk("len9_vld", 32'(upd_vld), 32'h0);

        // handshake and overrun on DR0
        din_parallel[0*MW +: MW] = 32'h89AB_CDEF;
        cap(0);
        push_bits(32'h89AB_CDEF, 32);
        shf(32'hCAFE_F00D, 32, 1'b1);
        upd();
        chk("hs1_sh", sh(0), 32'hCAFE_F00D);
        chk("hs1_vld", 32'(upd_vld), 32'h1);
        chk("hs1_ovr", 32'(upd_ovr), 32'h0);
        cap(0);
        shf(32'h0BAD_BEEF, 32, 1'b0);
        upd();
        chk("hs2_sh", sh(0), 32'h0BAD_BEEF);
        chk("hs2_vld", 32'(upd_vld), 32'h1);
        chk("hs2_ovr", 32'(upd_ovr), 32'h1);
        ovr_clr = 4'b0001;
        step();
        ovr_clr = '0;
        chk("hs_clr_ovr", 32'(upd_ovr), 32'h0);
        chk("hs_clr_vld", 32'(upd_vld), 32'h1);
        cap(0);
        shf(32'h1357_9BDF, 32, 1'b0);
        fsm_dr_update = 1'b1;
        upd_rdy = 4'b0001;
        step();
        fsm_dr_update = 1'b0;
        upd_rdy = '0;
        chk("hs3_sh", sh(0), 32'h1357_9BDF);
        chk("hs3_vld", 32'(upd_vld), 32'h1);
        chk("hs3_ovr", 32'(upd_ovr), 32'h0);
        // overrun set beats a simultaneous clear
        cap(0);
        shf(32'h2468_ACE0, 32, 1'b0);
        fsm_dr_update = 1'b1;
        ovr_clr = 4'b0001;
        step();
        fsm_dr_update = 1'b0;
        ovr_clr = '0;
        chk("hs4_ovr", 32'(upd_ovr), 32'h1);
        ovr_clr = 4'b0001;
        upd_rdy = 4'b0001;
        step();
        ovr_clr = '0;
        upd_rdy = '0;
        chk("hs4_ovr_clr", 32'(upd_ovr), 32'h0);
        chk("hs4_vld_clr", 32'(upd_vld), 32'h0);

        // BYPASS: one-bit delay, no side effects
        cap(NDR);
        sb_q.push_back(32'd0);
        sb_q.push_back(32'd1);
        sb_q.push_back(32'd1);
        sb_q.push_back(32'd0);
        shf(32'h0000_000B, 4, 1'b1);
        upd();
        chk("byp_vld", 32'(upd_vld), 32'h0);
        chk("byp_lerr", 32'(len_err), 32'h0);
        chk("byp_sh0", sh(0), 32'h2468_ACE0);
        chk("byp_sh1", sh(1), 32'h0000_1234);
        chk("byp_sh2", sh(2), 32'h0000_00FF);
        chk("byp_sh3", sh(3), 32'h0000_0001);

        // DR3, single-bit register
        din_parallel[3*MW +: MW] = 32'h0000_0003;
        cap(3);
        push_bits(32'h0000_0001, 1);
        shf(32'h0, 1, 1'b1);
        chk("dr3_tdo", 32'(dout_serial), 32'h0);
        upd();
        chk("dr3_sh", sh(3), 32'h0);
        chk("dr3_vld", 32'(upd_vld), 32'h8);
        upd_rdy = 4'b1000;
        step();
        upd_rdy = '0;

        // reset in the middle of a DR0 shift
        dr_sel = '0;
        cap(0);
        shf(32'h0000_001F, 5, 1'b0);
        fsm_dr_shift = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        fsm_dr_shift = 1'b0;
        chk_reset("mid_rst");
        din_parallel[0*MW +: MW] = 32'h7654_3210;
        cap(0);
        push_bits(32'h7654_3210, 32);
        shf(32'hFEDC_BA98, 32, 1'b1);
        upd();
        chk("post_rst_sh", sh(0), 32'hFEDC_BA98);
        chk("post_rst_vld", 32'(upd_vld), 32'h1);
        chk("post_rst_lerr", 32'(len_err), 32'h0);

        chk("sb_left", 32'(sb_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
